// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator gain-control logic.
// Contents: data/gain widths, full-scale codes, default AGC tuning values,
// the AGC state enum and a gain clamp helper.
package cic_pkg;

  localparam int CIC_DW = 20;  // CIC output sample width (signed)
  localparam int GAIN_W = 8;   // CIC Gain port width

  localparam logic [CIC_DW-1:0] FS_POS = 20'h7FFFF;  // +full scale
  localparam logic [CIC_DW-1:0] FS_NEG = 20'h80000;  // -full scale (no positive twin)

  localparam int                WIN_LOG2_DEF     = 8;
  localparam logic [CIC_DW-1:0] HI_THR_DEF       = 20'd393216;  // 0.75 FS
  localparam logic [CIC_DW-1:0] LO_THR_DEF       = 20'd98304;   // 0.1875 FS
  localparam int                ATTACK_STEP_DEF  = 2;
  localparam int                HOLD_SAMPLES_DEF = 64;
  localparam logic [GAIN_W-1:0] GAIN_MIN_DEF     = 8'd0;
  localparam logic [GAIN_W-1:0] GAIN_MAX_DEF     = 8'd48;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DECIDE  = 2'd3
  } agc_state_t;

  // Limit a gain code to [lo, hi].
  function automatic logic [GAIN_W-1:0] clamp_gain(input logic [GAIN_W-1:0] g,
                                                   input logic [GAIN_W-1:0] lo,
                                                   input logic [GAIN_W-1:0] hi);
    logic [GAIN_W-1:0] r;
    r = g;
    if (g > hi) r = hi;
    else if (g < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/cic_peak_det.sv
// Sample front end for the AGC: detects rising edges of the CIC output
// strobe, captures the sample, forms its saturated magnitude, tracks the
// window peak and flags overload samples.
// Ports:
//   i_osc_clk   clock (rising edge)
//   i_rst_n     synchronous reset, active low
//   i_d_clk     CIC output strobe level; a 0->1 transition marks a new sample
//   i_d_in      signed CIC output sample
//   i_peak_clr  clears the peak register (priority over update)
//   o_s_vld     one-cycle pulse: captured sample is valid this cycle
//   o_peak      largest magnitude seen since last clear
//   o_ovl       valid sample with magnitude >= HI_THR (combinational)
module cic_peak_det
  import cic_pkg::*;
#(
  parameter logic [CIC_DW-1:0] HI_THR = HI_THR_DEF
) (
  input  logic              i_osc_clk,
  input  logic              i_rst_n,
  input  logic              i_d_clk,
  input  logic [CIC_DW-1:0] i_d_in,
  input  logic              i_peak_clr,
  output logic              o_s_vld,
  output logic [CIC_DW-1:0] o_peak,
  output logic              o_ovl
);

  logic              r_dclk_d;
  logic              r_s_vld;
  logic [CIC_DW-1:0] r_sample;
  logic [CIC_DW-1:0] r_peak;
  logic [CIC_DW-1:0] w_mag;
  logic              w_dclk_rise;

  assign w_dclk_rise = i_d_clk & ~r_dclk_d;

  // Two's-complement negation of -FS wraps to itself, so pin it to +FS.
  always_comb begin
    w_mag = r_sample;
    if (r_sample == FS_NEG) w_mag = FS_POS;
    else if (r_sample[CIC_DW-1]) w_mag = -r_sample;
  end

  always_ff @(posedge i_osc_clk) begin
    if (!i_rst_n) begin
      r_dclk_d <= 1'b0;
      r_s_vld  <= 1'b0;
      r_sample <= '0;
      r_peak   <= '0;
    end else begin
      r_dclk_d <= i_d_clk;
      r_s_vld  <= w_dclk_rise;
      if (w_dclk_rise) r_sample <= i_d_in;
      if (i_peak_clr) r_peak <= '0;
      else if (r_s_vld && (w_mag > r_peak)) r_peak <= w_mag;
    end
  end

  assign o_s_vld = r_s_vld;
  assign o_peak  = r_peak;
  assign o_ovl   = r_s_vld && (w_mag >= HI_THR);

endmodule

// File: rtl/cic_agc_ctrl.sv
// Automatic gain controller for the CIC decimator Gain (output shift) port.
// Fast attack on overload samples, slow windowed decay when the window peak
// stays quiet, hold-off after every gain step, manual bypass.
// Ports:
//   i_osc_clk      clock (rising edge)
//   i_rst_n        synchronous reset, active low
//   i_agc_en       1 = automatic, 0 = gain follows i_manual_gain
//   i_manual_gain  manual gain code (clamped to GAIN_MIN..GAIN_MAX)
//   i_d_clk        CIC output strobe level
//   i_d_in         signed CIC output sample
//   o_gain         gain code to the CIC
//   o_gain_upd     one-cycle pulse when o_gain changes
//   o_overload     one-cycle pulse per sample with |d_in| >= HI_THR
//   o_agc_state    current FSM state (debug)
module cic_agc_ctrl
  import cic_pkg::*;
#(
  parameter int                WIN_LOG2     = WIN_LOG2_DEF,
  parameter logic [CIC_DW-1:0] HI_THR       = HI_THR_DEF,
  parameter logic [CIC_DW-1:0] LO_THR       = LO_THR_DEF,
  parameter int                ATTACK_STEP  = ATTACK_STEP_DEF,
  parameter int                HOLD_SAMPLES = HOLD_SAMPLES_DEF,
  parameter logic [GAIN_W-1:0] GAIN_MIN     = GAIN_MIN_DEF,
  parameter logic [GAIN_W-1:0] GAIN_MAX     = GAIN_MAX_DEF
) (
  input  logic              i_osc_clk,
  input  logic              i_rst_n,
  input  logic              i_agc_en,
  input  logic [GAIN_W-1:0] i_manual_gain,
  input  logic              i_d_clk,
  input  logic [CIC_DW-1:0] i_d_in,
  output logic [GAIN_W-1:0] o_gain,
  output logic              o_gain_upd,
  output logic              o_overload,
  output logic [1:0]        o_agc_state
);

  localparam int                HOLD_W    = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SAMPLES - 1);
  localparam logic [GAIN_W-1:0] ATK       = GAIN_W'(ATTACK_STEP);

  agc_state_t          r_state, w_state_next;
  logic [GAIN_W-1:0]   r_gain, w_gain_next;
  logic [WIN_LOG2-1:0] r_win_cnt, w_win_next;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_next;
  logic                r_gain_upd;
  logic                r_overload;

  logic                w_s_vld;
  logic                w_ovl;
  logic [CIC_DW-1:0]   w_peak;
  logic                w_peak_clr;

  // The peak only accumulates while measuring; every other state keeps it
  // at zero so a fresh window always starts clean. DECIDE still sees the
  // full window peak because the clear lands at the end of that cycle.
  assign w_peak_clr = (r_state != ST_MEASURE);

  cic_peak_det #(
    .HI_THR(HI_THR)
  ) u_peak_det (
    .i_osc_clk (i_osc_clk),
    .i_rst_n   (i_rst_n),
    .i_d_clk   (i_d_clk),
    .i_d_in    (i_d_in),
    .i_peak_clr(w_peak_clr),
    .o_s_vld   (w_s_vld),
    .o_peak    (w_peak),
    .o_ovl     (w_ovl)
  );

  always_comb begin
    w_state_next = r_state;
    w_gain_next  = r_gain;
    w_win_next   = r_win_cnt;
    w_hold_next  = r_hold_cnt;

    case (r_state)
      ST_IDLE: begin
        w_gain_next = clamp_gain(i_manual_gain, GAIN_MIN, GAIN_MAX);
        if (i_agc_en) w_state_next = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (w_s_vld) begin
          // Attack takes priority even on the last sample of a window.
          if (w_ovl) begin
            if ((r_gain - GAIN_MIN) >= ATK) w_gain_next = r_gain - ATK;
            else w_gain_next = GAIN_MIN;
            w_state_next = ST_HOLD;
          end else begin
            w_win_next = r_win_cnt + 1'b1;
            if (r_win_cnt == '1) w_state_next = ST_DECIDE;
          end
        end
      end
      ST_DECIDE: begin
        if ((w_peak < LO_THR) && (r_gain < GAIN_MAX)) begin
          w_gain_next  = r_gain + 1'b1;
          w_state_next = ST_HOLD;
        end else begin
          w_state_next = ST_MEASURE;
        end
      end
      ST_HOLD: begin
        if (w_s_vld) begin
          if (r_hold_cnt == HOLD_LAST) w_state_next = ST_MEASURE;
          else w_hold_next = r_hold_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Disabling freezes the gain for one cycle; IDLE then loads the manual code.
    if (!i_agc_en && (r_state != ST_IDLE)) begin
      w_state_next = ST_IDLE;
      w_gain_next  = r_gain;
    end

    if (w_state_next != ST_MEASURE) w_win_next = '0;
    if (w_state_next != ST_HOLD) w_hold_next = '0;
  end

  always_ff @(posedge i_osc_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_gain     <= GAIN_MIN;
      r_win_cnt  <= '0;
      r_hold_cnt <= '0;
      r_gain_upd <= 1'b0;
      r_overload <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_gain     <= w_gain_next;
      r_win_cnt  <= w_win_next;
      r_hold_cnt <= w_hold_next;
      r_gain_upd <= (w_gain_next != r_gain);
      r_overload <= w_ovl;
    end
  end

  assign o_gain      = r_gain;
  assign o_gain_upd  = r_gain_upd;
  assign o_overload  = r_overload;
  assign o_agc_state = r_state;

endmodule

// File: tb/tb_cic_agc_ctrl.sv
// Self-checking bench for cic_agc_ctrl: reset, manual-mode vector table,
// hand-written decay/attack/corner sequences and a randomized run checked
// against a per-sample behavioural model.
module tb_cic_agc_ctrl;

  localparam int HI  = 393216;
  localparam int LO  = 98304;
  localparam int GMAX = 48;

  logic        clk;
  logic        rst_n;
  logic        agc_en;
  logic [7:0]  manual_gain;
  logic        d_clk;
  logic [19:0] d_in;
  logic [7:0]  gain;
  logic        gain_upd;
  logic        overload;
  logic [1:0]  agc_state;

  int checks   = 0;
  int failures = 0;
  int upd_seen = 0;
  int ovl_seen = 0;

  cic_agc_ctrl dut (
    .i_osc_clk    (clk),
    .i_rst_n      (rst_n),
    .i_agc_en     (agc_en),
    .i_manual_gain(manual_gain),
    .i_d_clk      (d_clk),
    .i_d_in       (d_in),
    .o_gain       (gain),
    .o_gain_upd   (gain_upd),
    .o_overload   (overload),
    .o_agc_state  (agc_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, updated just after each falling edge.
  always @(negedge clk) begin
    #1;
    if (gain_upd === 1'b1) upd_seen++;
    if (overload === 1'b1) ovl_seen++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] enc(input int v);
    logic [19:0] r;
    r = v[19:0];
    return r;
  endfunction

  function automatic int mag_of(input logic [19:0] x);
    int v;
    v = $signed(x);
    if (v < 0) v = -v;
    if (v > 524287) v = 524287;
    return v;
  endfunction

  // One sample, 6 clock cycles apart from the next.
  task automatic send(input logic [19:0] x);
    d_in  = x;
    d_clk = 1'b1;
    @(negedge clk);
    d_clk = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  logic [7:0] p_gain [3];
  logic       p_upd  [3];
  logic       p_ovl  [3];
  logic [1:0] p_state[3];

  // Like send, but snapshots outputs 1, 2 and 3 falling edges after the drive.
  task automatic send_probe(input logic [19:0] x);
    d_in  = x;
    d_clk = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) d_clk = 1'b0;
      p_gain[k]  = gain;
      p_upd[k]   = gain_upd;
      p_ovl[k]   = overload;
      p_state[k] = agc_state;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic set_manual(input int g);
    agc_en      = 1'b0;
    manual_gain = 8'(g);
    repeat (2) @(negedge clk);
    agc_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) send(enc((i % 2) ? -1000 : 1000));
  endtask

  // Behavioural model, one call per sample while automatic mode is on.
  int m_gain, m_hold_left, m_win_n, m_peak, exp_upd, exp_ovl;
  bit m_holding;

  task automatic model_sample(input int mag);
    int ng;
    if (mag >= HI) exp_ovl++;
    if (m_holding) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_holding = 0;
        m_win_n   = 0;
        m_peak    = 0;
      end
    end else if (mag >= HI) begin
      ng = (m_gain - 2 < 0) ? 0 : m_gain - 2;
      if (ng != m_gain) exp_upd++;
      m_gain      = ng;
      m_holding   = 1;
      m_hold_left = 64;
      m_win_n     = 0;
      m_peak      = 0;
    end else begin
      if (mag > m_peak) m_peak = mag;
      m_win_n++;
      if (m_win_n == 256) begin
        if (m_peak < LO && m_gain < GMAX) begin
          m_gain++;
          exp_upd++;
          m_holding   = 1;
          m_hold_left = 64;
        end
        m_win_n = 0;
        m_peak  = 0;
      end
    end
  endtask

  typedef struct {
    logic [7:0] man;
    logic [7:0] exp_gain;
    logic       exp_upd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int u0, o0, r, mg, v;
    logic [19:0] x;

    tbl[0] = '{8'd0,   8'd0,  1'b0};
    tbl[1] = '{8'd5,   8'd5,  1'b1};
    tbl[2] = '{8'd5,   8'd5,  1'b0};
    tbl[3] = '{8'd47,  8'd47, 1'b1};
    tbl[4] = '{8'd48,  8'd48, 1'b1};
    tbl[5] = '{8'd49,  8'd48, 1'b0};
    tbl[6] = '{8'd200, 8'd48, 1'b0};
    tbl[7] = '{8'd255, 8'd48, 1'b0};
    tbl[8] = '{8'd12,  8'd12, 1'b1};
    tbl[9] = '{8'd0,   8'd0,  1'b1};

    // Reset held with a busy, overloading input.
    rst_n = 1'b0; agc_en = 1'b1; manual_gain = 8'd30;
    d_in = 20'h80000; d_clk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d_clk = ~d_clk;
      @(negedge clk);
      chk("rst_gain", int'(gain), 0);
      chk("rst_upd", int'(gain_upd), 0);
      chk("rst_ovl", int'(overload), 0);
      chk("rst_state", int'(agc_state), 0);
      $display("reset cycle %0d gain=%0d state=%0d", i, gain, agc_state);
    end
    agc_en = 1'b0; manual_gain = 8'd0; d_clk = 1'b0; d_in = '0; rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Manual mode table.
    for (int i = 0; i < 10; i++) begin
      manual_gain = tbl[i].man;
      @(negedge clk);
      chk("man_gain", int'(gain), int'(tbl[i].exp_gain));
      chk("man_upd", int'(gain_upd), int'(tbl[i].exp_upd));
      chk("man_state", int'(agc_state), 0);
      $display("manual %0d -> gain=%0d upd=%0d", tbl[i].man, gain, gain_upd);
    end

    // Decay: three quiet windows, one step each.
    agc_en = 1'b1;
    @(negedge clk);
    chk("dec_state_meas", int'(agc_state), 1);
    u0 = upd_seen;
    for (int w = 0; w < 3; w++) begin
      quiet(255);
      chk("dec_pre_gain", int'(gain), w);
      send_probe(enc(1000));
      chk("dec_decide_state", int'(p_state[1]), 3);
      chk("dec_decide_gain", int'(p_gain[1]), w);
      chk("dec_step_gain", int'(p_gain[2]), w + 1);
      chk("dec_step_upd", int'(p_upd[2]), 1);
      chk("dec_hold_state", int'(p_state[2]), 2);
      quiet(63);
      chk("dec_hold_gain", int'(gain), w + 1);
      chk("dec_hold_state2", int'(agc_state), 2);
      quiet(1);
      chk("dec_back_meas", int'(agc_state), 1);
      $display("decay window %0d gain=%0d", w, gain);
    end
    chk("dec_upd_count", upd_seen - u0, 3);

    // Attack from gain 10, then a held-off overload burst.
    set_manual(10);
    chk("atk_start_gain", int'(gain), 10);
    send_probe(enc(450000));
    chk("atk_e0_gain", int'(p_gain[0]), 10);
    chk("atk_e0_ovl", int'(p_ovl[0]), 0);
    chk("atk_e1_gain", int'(p_gain[1]), 8);
    chk("atk_e1_ovl", int'(p_ovl[1]), 1);
    chk("atk_e1_upd", int'(p_upd[1]), 1);
    chk("atk_e1_state", int'(p_state[1]), 2);
    chk("atk_e2_ovl", int'(p_ovl[2]), 0);
    chk("atk_e2_upd", int'(p_upd[2]), 0);
    u0 = upd_seen; o0 = ovl_seen;
    for (int i = 0; i < 64; i++) send(enc(500000));
    chk("hold_ovl_count", ovl_seen - o0, 64);
    chk("hold_upd_count", upd_seen - u0, 0);
    chk("hold_gain", int'(gain), 8);
    chk("hold_exit_state", int'(agc_state), 1);
    $display("attack gain=%0d", gain);

    // Floor: 1 -> 0, then overload at 0 changes nothing but still holds.
    set_manual(1);
    u0 = upd_seen;
    send(enc(400000));
    chk("floor_gain", int'(gain), 0);
    chk("floor_upd", upd_seen - u0, 1);
    quiet(64);
    u0 = upd_seen; o0 = ovl_seen;
    send_probe(enc(-400000));
    chk("min_ovl_upd", upd_seen - u0, 0);
    chk("min_ovl_count", ovl_seen - o0, 1);
    chk("min_ovl_gain", int'(gain), 0);
    chk("min_ovl_state", int'(p_state[1]), 2);
    quiet(64);
    $display("floor gain=%0d", gain);

    // Most negative code saturates and overloads.
    o0 = ovl_seen;
    send_probe(20'h80000);
    chk("sat_ovl", int'(p_ovl[1]), 1);
    chk("sat_state", int'(p_state[1]), 2);
    chk("sat_ovl_count", ovl_seen - o0, 1);
    quiet(64);

    // Overload on the 256th sample: attack, no decay.
    set_manual(5);
    quiet(255);
    send_probe(enc(400000));
    chk("edge_gain1", int'(p_gain[1]), 3);
    chk("edge_state1", int'(p_state[1]), 2);
    chk("edge_gain2", int'(p_gain[2]), 3);
    chk("edge_state2", int'(p_state[2]), 2);
    quiet(64);
    $display("window-edge attack gain=%0d", gain);

    // Ceiling: quiet window at 48 keeps 48.
    set_manual(48);
    quiet(255);
    send_probe(enc(1000));
    chk("ceil_decide", int'(p_state[1]), 3);
    chk("ceil_gain", int'(p_gain[2]), 48);
    chk("ceil_upd", int'(p_upd[2]), 0);
    chk("ceil_state", int'(p_state[2]), 1);
    $display("ceiling gain=%0d", gain);

    // Manual takeover during hold.
    send(enc(400000));
    chk("mid_gain", int'(gain), 46);
    quiet(10);
    agc_en = 1'b0; manual_gain = 8'd200;
    @(negedge clk);
    chk("mid_off_state", int'(agc_state), 0);
    chk("mid_off_gain", int'(gain), 46);
    @(negedge clk);
    chk("mid_man_gain", int'(gain), 48);
    chk("mid_man_upd", int'(gain_upd), 1);

    // Reset in hold.
    agc_en = 1'b1;
    @(negedge clk);
    send(enc(400000));
    quiet(5);
    chk("pre_rst_state", int'(agc_state), 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("hrst_gain", int'(gain), 0);
    chk("hrst_state", int'(agc_state), 0);
    chk("hrst_upd", int'(gain_upd), 0);
    rst_n = 1'b1; agc_en = 1'b0; manual_gain = 8'd0;
    @(negedge clk);
    chk("post_rst_state", int'(agc_state), 0);
    $display("reset in hold gain=%0d", gain);

    // Randomized run against the behavioural model.
    set_manual($urandom_range(0, 48));
    m_gain = int'(manual_gain); m_holding = 0; m_hold_left = 0;
    m_win_n = 0; m_peak = 0; exp_upd = 0; exp_ovl = 0;
    chk("rnd_start_gain", int'(gain), m_gain);
    u0 = upd_seen; o0 = ovl_seen;
    for (int seg = 0; seg < 6; seg++) begin
      for (int n = 0; n < 350; n++) begin
        r = $urandom_range(0, 999);
        if ((seg % 2 == 0) ? (r < 3) : (r >= 900)) mg = $urandom_range(HI, 524288);
        else if ((seg % 2 == 1) && (r >= 600)) mg = $urandom_range(LO, HI - 1);
        else mg = $urandom_range(0, LO - 1);
        v = ($urandom_range(0, 1) == 1 || mg == 524288) ? -mg : mg;
        x = enc(v);
        send(x);
        v = m_gain;
        model_sample(mag_of(x));
        chk("rnd_gain", int'(gain), m_gain);
        chk("rnd_upd", upd_seen - u0, exp_upd);
        chk("rnd_ovl", ovl_seen - o0, exp_ovl);
        if (v != m_gain) $display("rnd seg %0d sample %0d gain %0d -> %0d", seg, n, v, m_gain);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
